// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Desc   : Shared fetch-stage types, vectors and IF/ID field helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_BUF   = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_PC4_LSB   = 32;
    localparam int IFID_W         = 64;

    function automatic logic [IFID_W-1:0] ifid_pack(input logic [31:0] pc4,
                                                     input logic [31:0] instr);
        logic [IFID_W-1:0] r;
        r = '0;
        r[IFID_PC4_LSB   +: 32] = pc4;
        r[IFID_INSTR_LSB +: 32] = instr;
        return r;
    endfunction

    // The kernel flag in bit 31 never carries in from the increment.
    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module : if_stage_if
// Desc   : Instruction-memory req/ack fetch bus between IF stage and imem.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

`default_nettype wire

// File: rtl/if_pc_sel.sv
// ============================================================================
// Module : if_pc_sel
// Desc   : Combinational redirect-priority mux producing {redirect, target}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_pc_sel #(
    parameter logic [31:0] IRQ_VEC = cpu_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC = cpu_pkg::EXC_VEC
) (
    input  wire logic        bubble,
    input  wire logic        pc_src_j,
    input  wire logic [31:0] jump_address,
    input  wire logic        pc_src_jr,
    input  wire logic [31:0] jr_address,
    input  wire logic        exception,
    input  wire logic        irq_take,
    input  wire logic        ex_br_taken,
    input  wire logic [31:0] ex_br_address,
    output logic             redirect_o,
    output logic [31:0]      target_o
);

    always_comb begin
        redirect_o = 1'b0;
        target_o   = 32'h0;
        // Decode-sourced redirects wait while their instruction is held in decode.
        if (ex_br_taken) begin
            redirect_o = 1'b1;
            target_o   = ex_br_address;
        end else if (!bubble) begin
            if (exception) begin
                redirect_o = 1'b1;
                target_o   = EXC_VEC;
            end else if (irq_take) begin
                redirect_o = 1'b1;
                target_o   = IRQ_VEC;
            end else if (pc_src_jr) begin
                redirect_o = 1'b1;
                target_o   = jr_address;
            end else if (pc_src_j) begin
                redirect_o = 1'b1;
                target_o   = jump_address;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module : if_stage
// Desc   : Instruction-fetch stage: PC, IF/ID register, variable-latency fetch.
//          Optional IF_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] IRQ_VEC  = cpu_pkg::IRQ_VEC,
    parameter logic [31:0] EXC_VEC  = cpu_pkg::EXC_VEC
) (
    input  wire logic        clk,
    input  wire logic        reset_b,
    input  wire logic        bubble,
    input  wire logic        pc_src_j,
    input  wire logic [31:0] jump_address,
    input  wire logic        pc_src_jr,
    input  wire logic [31:0] jr_address,
    input  wire logic        exception,
    input  wire logic        irq_take,
    input  wire logic        ex_br_taken,
    input  wire logic [31:0] ex_br_address,
    if_stage_if.master       imem,
    output logic [63:0]      IF_ID,
    output logic [31:0]      pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    import cpu_pkg::*;

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [63:0] if_id_q;
    logic [31:0] buf_q;
    logic [31:0] tgt_q;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    if_pc_sel #(.IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) u_pc_sel (
        .bubble        (bubble),
        .pc_src_j      (pc_src_j),
        .jump_address  (jump_address),
        .pc_src_jr     (pc_src_jr),
        .jr_address    (jr_address),
        .exception     (exception),
        .irq_take      (irq_take),
        .ex_br_taken   (ex_br_taken),
        .ex_br_address (ex_br_address),
        .redirect_o    (redirect),
        .target_o      (target)
    );

    assign pc_plus4       = pc_inc(pc_q);
    assign imem.imem_req  = reset_b && (state_q != ST_BUF);
    assign imem.imem_addr = pc_q;
    assign IF_ID          = if_id_q;
    assign pc             = pc_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            if_id_q <= '0;
            buf_q   <= NOP_WORD;
            tgt_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (redirect) begin
                        if_id_q <= '0;
                        // Without ack the request is still in flight; keep its address.
                        if (imem.imem_ack) begin
                            pc_q <= target;
                        end else begin
                            tgt_q   <= target;
                            state_q <= ST_DROP;
                        end
                    end else if (imem.imem_ack) begin
                        if (!bubble) begin
                            if_id_q <= ifid_pack(pc_plus4, imem.imem_rdata);
                            pc_q    <= pc_plus4;
                        end else begin
                            buf_q   <= imem.imem_rdata;
                            state_q <= ST_BUF;
                        end
                    end else if (!bubble) begin
                        if_id_q <= '0;
                    end
                end
                ST_DROP: begin
                    if_id_q <= '0;
                    if (imem.imem_ack) begin
                        pc_q    <= redirect ? target : tgt_q;
                        state_q <= ST_FETCH;
                    end else if (redirect) begin
                        tgt_q <= target;
                    end
                end
                ST_BUF: begin
                    if (redirect) begin
                        if_id_q <= '0;
                        pc_q    <= target;
                        state_q <= ST_FETCH;
                    end else if (!bubble) begin
                        if_id_q <= ifid_pack(pc_plus4, buf_q);
                        pc_q    <= pc_plus4;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        ifid_load;
    logic [31:0] ifid_instr;

    always_comb begin
        ifid_load  = 1'b0;
        ifid_instr = NOP_WORD;
        if (!redirect && !bubble) begin
            if (state_q == ST_FETCH && imem.imem_ack) begin
                ifid_load  = 1'b1;
                ifid_instr = imem.imem_rdata;
            end else if (state_q == ST_BUF) begin
                ifid_load  = 1'b1;
                ifid_instr = buf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ifid_load && (ifid_instr != NOP_WORD)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bubble || (imem.imem_req && !imem.imem_ack)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage.
- Owns the PC register and the IF/ID pipeline register, which feeds decode as {PC_Plus4, Instruction}.
- Fetches from instruction memory over a req/ack handshake that tolerates variable latency.
- Applies redirects from EX (branch), decode (J/JR/exception/IRQ) and load-use stall.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset (kernel mode, bit31=1)
- IRQ_VEC, 32'h8000_0004, interrupt target
- EXC_VEC, 32'h8000_0008, exception/illegal-op target

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous, active-low reset
- bubble  in  1  load-use stall from decode; hold PC and IF_ID
- pc_src_j  in  1  decode J/JAL redirect
- jump_address  in  32  J target
- pc_src_jr  in  1  decode JR/JALR redirect
- jr_address  in  32  JR target
- exception  in  1  decode exception redirect
- irq_take  in  1  decode interrupt redirect
- ex_br_taken  in  1  EX-stage branch resolved taken
- ex_br_address  in  32  branch target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= PC)
- imem_ack  in  1  response valid for imem_addr
- imem_rdata  in  32  instruction word
- IF_ID  out  64  [31:0] Instruction, [63:32] PC_Plus4
- pc  out  32  current PC (debug)

Behaviour:
- Reset (async, reset_b low): pc=RESET_PC; IF_ID=0 (NOP); state=FETCH; buf=0; tgt=0. imem_req=0 while reset_b is low.
- PC_Plus4 = {pc[31], pc[30:0]+4}. Bit 31 (kernel flag) is never altered by increment.
- Redirect priority: ex_br_taken > exception > irq_take > pc_src_jr > pc_src_j.
  - The chosen target is the redirect target for that cycle.
  - The four decode-sourced redirects are ignored while bubble=1, because the redirecting instruction is still held in decode.
  - ex_br_taken is honoured regardless of bubble.
- Any redirect writes IF_ID<=0 (squashes the wrong-path instruction).
- imem_req=1 in FETCH and DROP, 0 in BUF. imem_addr=pc. The address stays stable until ack; ack may arrive in the same cycle as req or any later cycle.
- State FETCH:
  - ack=1, no redirect, bubble=0: IF_ID<={PC_Plus4, imem_rdata}; pc<=PC_Plus4.
  - ack=1, no redirect, bubble=1: buf<=imem_rdata; pc and IF_ID hold; ->BUF.
  - ack=0, no redirect: IF_ID<=0 if bubble=0, else hold; pc holds.
  - redirect, ack=1: discard data; pc<=target; stay FETCH.
  - redirect, ack=0: tgt<=target; ->DROP. pc holds so the outstanding address stays stable.
- State DROP (waiting out a stale request):
  - IF_ID<=0 every cycle.
  - A new redirect overwrites tgt.
  - On ack: data discarded; pc<=(redirect this cycle ? target : tgt); ->FETCH.
- State BUF:
  - bubble=1, no redirect: hold.
  - bubble=0, no redirect: IF_ID<={PC_Plus4, buf}; pc<=PC_Plus4; ->FETCH.
  - redirect: buf discarded; pc<=target; ->FETCH.
- Latency: with zero-wait memory, one instruction per cycle. Redirect penalty: the next fetch of the target issues in the cycle after the redirect.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_cnt increments when a non-NOP is written into IF_ID.
  - stall_cnt increments on each cycle with bubble=1 or with imem_req=1 && imem_ack=0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - FSM state enum (FETCH, DROP, BUF)
  - vector constants RESET_PC, IRQ_VEC, EXC_VEC
  - NOP word 32'h0
  - IF_ID field offsets
- One natural sub-module: if_pc_sel, a combinational redirect-priority mux producing {redirect, target}.

Test Plan:
- Reset, zero-wait ack: imem_addr sequence 80000000, 80000004, 80000008. IF_ID[63:32]=80000004 after the first ack.
- ack delayed 2 cycles at pc=80000010: IF_ID=0 for 2 cycles, pc holds. On ack, IF_ID={80000014, rdata}.
- pc_src_j=1 (jump_address=00400020) with ack=0: ->DROP, IF_ID=0. Stale ack discarded. Next imem_addr=00400020.
- bubble=1 with ack=1 (rdata=DEADBEEF): IF_ID holds, ->BUF, imem_req=0. On bubble=0, IF_ID[31:0]=DEADBEEF.
- ex_br_taken=1 (ex_br_address=00400100) and exception=1 in the same cycle: pc<=00400100, IF_ID=0.
- pc_src_jr=1 while bubble=1: ignored, pc holds. reset_b low mid-DROP: pc=80000000, IF_ID=0 immediately.
